intc_apb_arb: RTL

- Round-robin APB arbiter that shares the single interrupt-controller APB slave port (CLINT/PLIC register space) between N_MST requesters, e.g. one per hart plus a debug master.
- Each requester sees an APB slave port that is held in wait state until granted.
- The arbiter replays the held request as a clean SETUP/ACCESS transfer on the downstream port and returns a registered response.
- A per-transfer timeout turns a hung slave into an error response.

---
 rtl/intc_arb_pkg.sv | 21 ++
 rtl/intc_apb_arb_rr_pick.sv | 31 +++
 rtl/intc_apb_arb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/intc_arb_pkg.sv
// Shared types and constants for the interrupt-controller APB arbiter.
package intc_arb_pkg;

    localparam int APB_AW     = 32;
    localparam int APB_DW     = 32;
    localparam int APB_SW     = APB_DW / 8;
    localparam int TO_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Reads never carry byte strobes downstream.
    function automatic logic [APB_SW-1:0] strb_mask(input logic pwrite, input logic [APB_SW-1:0] pstrb);
        strb_mask = pwrite ? pstrb : {APB_SW{1'b0}};
    endfunction

endpackage

// File: rtl/intc_apb_arb_rr_pick.sv
// Combinational round-robin first-one finder: returns the first set request
// strictly after the pointer position, wrapping modulo N.
module rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_vld,
    output logic [W-1:0] o_idx
);

    logic [W-1:0] w_pos;

    // Walk the slots after the pointer once around the ring; keep the first hit.
    always_comb begin
        o_vld = 1'b0;
        o_idx = {W{1'b0}};
        w_pos = i_ptr;
        for (int k = 0; k < N; k++) begin
            w_pos = (w_pos == W'(N - 1)) ? {W{1'b0}} : w_pos + W'(1);
            if (i_req[w_pos] && !o_vld) begin
                o_vld = 1'b1;
                o_idx = w_pos;
            end else begin
                o_vld = o_vld;
            end
        end
    end

endmodule

// File: rtl/intc_apb_arb.sv
// Round-robin APB arbiter sharing one interrupt-controller slave port between
// N_MST requesters, with a per-transfer ACCESS timeout.
module intc_apb_arb
    import intc_arb_pkg::*;
#(
    parameter int N_MST  = 2,
    parameter int TO_CYC = TO_CYC_DEF,
    parameter int GNT_W  = $clog2(N_MST)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_MST-1:0]          s_psel,
    input  logic [N_MST-1:0]          s_penable,
    input  logic [N_MST*APB_AW-1:0]   s_paddr,
    input  logic [N_MST-1:0]          s_pwrite,
    input  logic [N_MST*APB_SW-1:0]   s_pstrb,
    input  logic [N_MST*APB_DW-1:0]   s_pwdata,
    output logic [APB_DW-1:0]         s_prdata,
    output logic [N_MST-1:0]          s_pslverr,
    output logic [N_MST-1:0]          s_pready,
    output logic                      m_psel,
    output logic                      m_penable,
    output logic [APB_AW-1:0]         m_paddr,
    output logic                      m_pwrite,
    output logic [APB_SW-1:0]         m_pstrb,
    output logic [APB_DW-1:0]         m_pwdata,
    input  logic [APB_DW-1:0]         m_prdata,
    input  logic                      m_pslverr,
    input  logic                      m_pready,
    output logic [GNT_W-1:0]          gnt_id,
    output logic                      to_evt
);

    // A zero TO_CYC still gets a 1-bit counter; it simply saturates.
    localparam int                CNT_W    = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (TO_CYC > 0) ? CNT_W'(TO_CYC - 1) : {CNT_W{1'b0}};
    localparam logic [GNT_W-1:0]  PTR_RST  = GNT_W'(N_MST - 1);

    arb_state_e         r_state, w_state_nxt;
    logic [GNT_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [GNT_W-1:0]   r_gnt_id, w_gnt_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_m_psel, w_m_psel_nxt;
    logic               r_m_penable, w_m_penable_nxt;
    logic [APB_AW-1:0]  r_m_paddr, w_m_paddr_nxt;
    logic               r_m_pwrite, w_m_pwrite_nxt;
    logic [APB_SW-1:0]  r_m_pstrb, w_m_pstrb_nxt;
    logic [APB_DW-1:0]  r_m_pwdata, w_m_pwdata_nxt;
    logic [APB_DW-1:0]  r_s_prdata, w_s_prdata_nxt;
    logic [N_MST-1:0]   r_s_pslverr, w_s_pslverr_nxt;
    logic [N_MST-1:0]   r_s_pready, w_s_pready_nxt;
    logic               r_to_evt, w_to_evt_nxt;

    logic               w_pick_vld;
    logic [GNT_W-1:0]   w_pick_idx;
    logic [N_MST-1:0]   w_gnt_oh;
    logic [APB_AW-1:0]  w_paddr_a  [N_MST];
    logic [APB_SW-1:0]  w_pstrb_a  [N_MST];
    logic [APB_DW-1:0]  w_pwdata_a [N_MST];
    logic [N_MST-1:0]   w_unused_penable;

    assign w_unused_penable = s_penable;

    for (genvar g = 0; g < N_MST; g++) begin : g_unpack
        assign w_paddr_a[g]  = s_paddr[g*APB_AW +: APB_AW];
        assign w_pstrb_a[g]  = s_pstrb[g*APB_SW +: APB_SW];
        assign w_pwdata_a[g] = s_pwdata[g*APB_DW +: APB_DW];
    end

    rr_pick #(
        .N (N_MST),
        .W (GNT_W)
    ) u_rr_pick (
        .i_req (s_psel),
        .i_ptr (r_rr_ptr),
        .o_vld (w_pick_vld),
        .o_idx (w_pick_idx)
    );

    assign w_gnt_oh = {{(N_MST-1){1'b0}}, 1'b1} << r_gnt_id;

    // Next-state and next-output decode for the transfer sequencer.
    always_comb begin
        w_state_nxt      = r_state;
        w_rr_nxt         = r_rr_ptr;
        w_gnt_nxt        = r_gnt_id;
        w_cnt_nxt        = r_cnt;
        w_m_psel_nxt     = r_m_psel;
        w_m_penable_nxt  = r_m_penable;
        w_m_paddr_nxt    = r_m_paddr;
        w_m_pwrite_nxt   = r_m_pwrite;
        w_m_pstrb_nxt    = r_m_pstrb;
        w_m_pwdata_nxt   = r_m_pwdata;
        w_s_prdata_nxt   = r_s_prdata;
        w_s_pslverr_nxt  = {N_MST{1'b0}};
        w_s_pready_nxt   = {N_MST{1'b0}};
        w_to_evt_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_gnt_nxt       = w_pick_idx;
                    w_m_paddr_nxt   = w_paddr_a[w_pick_idx];
                    w_m_pwrite_nxt  = s_pwrite[w_pick_idx];
                    w_m_pstrb_nxt   = strb_mask(s_pwrite[w_pick_idx], w_pstrb_a[w_pick_idx]);
                    w_m_pwdata_nxt  = w_pwdata_a[w_pick_idx];
                    w_m_psel_nxt    = 1'b1;
                    w_m_penable_nxt = 1'b0;
                    w_state_nxt     = SETUP;
                end else begin
                    w_state_nxt     = IDLE;
                end
            end
            SETUP: begin
                w_m_penable_nxt = 1'b1;
                w_cnt_nxt       = {CNT_W{1'b0}};
                w_state_nxt     = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over a timeout landing on the same cycle.
                if (m_pready) begin
                    w_s_prdata_nxt  = r_m_pwrite ? {APB_DW{1'b0}} : m_prdata;
                    w_s_pslverr_nxt = m_pslverr ? w_gnt_oh : {N_MST{1'b0}};
                    w_s_pready_nxt  = w_gnt_oh;
                    w_m_psel_nxt    = 1'b0;
                    w_m_penable_nxt = 1'b0;
                    w_rr_nxt        = r_gnt_id;
                    w_state_nxt     = RESP;
                end else if ((TO_CYC != 0) && (r_cnt == CNT_LAST)) begin
                    w_s_prdata_nxt  = {APB_DW{1'b0}};
                    w_s_pslverr_nxt = w_gnt_oh;
                    w_s_pready_nxt  = w_gnt_oh;
                    w_to_evt_nxt    = 1'b1;
                    w_m_psel_nxt    = 1'b0;
                    w_m_penable_nxt = 1'b0;
                    w_rr_nxt        = r_gnt_id;
                    w_state_nxt     = RESP;
                end else begin
                    w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_m_psel_nxt    = 1'b0;
                w_m_penable_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_rr_ptr    <= PTR_RST;
            r_gnt_id    <= {GNT_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_m_psel    <= 1'b0;
            r_m_penable <= 1'b0;
            r_m_paddr   <= {APB_AW{1'b0}};
            r_m_pwrite  <= 1'b0;
            r_m_pstrb   <= {APB_SW{1'b0}};
            r_m_pwdata  <= {APB_DW{1'b0}};
            r_s_prdata  <= {APB_DW{1'b0}};
            r_s_pslverr <= {N_MST{1'b0}};
            r_s_pready  <= {N_MST{1'b0}};
            r_to_evt    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_gnt_id    <= w_gnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_m_psel    <= w_m_psel_nxt;
            r_m_penable <= w_m_penable_nxt;
            r_m_paddr   <= w_m_paddr_nxt;
            r_m_pwrite  <= w_m_pwrite_nxt;
            r_m_pstrb   <= w_m_pstrb_nxt;
            r_m_pwdata  <= w_m_pwdata_nxt;
            r_s_prdata  <= w_s_prdata_nxt;
            r_s_pslverr <= w_s_pslverr_nxt;
            r_s_pready  <= w_s_pready_nxt;
            r_to_evt    <= w_to_evt_nxt;
        end
    end

    assign s_prdata  = r_s_prdata;
    assign s_pslverr = r_s_pslverr;
    assign s_pready  = r_s_pready;
    assign m_psel    = r_m_psel;
    assign m_penable = r_m_penable;
    assign m_paddr   = r_m_paddr;
    assign m_pwrite  = r_m_pwrite;
    assign m_pstrb   = r_m_pstrb;
    assign m_pwdata  = r_m_pwdata;
    assign gnt_id    = r_gnt_id;
    assign to_evt    = r_to_evt;

endmodule
